// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the single ROB/PRF write port between N_REQ execute units,
// granting the oldest pending result (ROB age from ROB_h) and dropping squashed results.
module wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int DW    = 32,
  parameter int IDXW  = 3,
  parameter int PRW   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*DW-1:0]    req_data,
  input  logic [N_REQ*IDXW-1:0]  req_rob_idx,
  input  logic [N_REQ*PRW-1:0]   req_P_rd,
  input  logic [IDXW-1:0]        ROB_h,
  input  logic                   mispredict,
  input  logic [2**IDXW-1:0]     flush_mask,
  output logic                   WB_valid,
  output logic [DW-1:0]          WB_data,
  output logic [IDXW-1:0]        WB_rob_idx,
  output logic [PRW-1:0]         WB_P_rd,
  output logic [15:0]            drop_cnt
);

  localparam int CW = $clog2(N_REQ + 2);

  logic [N_REQ-1:0] slot_v;
  logic [DW-1:0]    slot_data [N_REQ];
  logic [IDXW-1:0]  slot_idx  [N_REQ];
  logic [PRW-1:0]   slot_prd  [N_REQ];

  logic             wb_v_r;
  logic [DW-1:0]    wb_data_r;
  logic [IDXW-1:0]  wb_idx_r;
  logic [PRW-1:0]   wb_prd_r;
  logic [15:0]      drop_cnt_r;

  logic [N_REQ-1:0] cand_v;
  logic [N_REQ-1:0] cand_flush;
  logic [N_REQ-1:0] cand_live;
  logic [DW-1:0]    cand_data [N_REQ];
  logic [IDXW-1:0]  cand_idx  [N_REQ];
  logic [PRW-1:0]   cand_prd  [N_REQ];
  logic [IDXW-1:0]  cand_age  [N_REQ];

  logic             win_any;
  logic [N_REQ-1:0] win_onehot;
  logic [IDXW-1:0]  best_age;
  logic [DW-1:0]    win_data;
  logic [IDXW-1:0]  win_idx;
  logic [PRW-1:0]   win_prd;

  logic             out_kill;
  logic [CW-1:0]    drop_inc;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_next;

  // A held slot takes precedence over the live request; a full slot keeps ready low anyway.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cand_v[i]     = slot_v[i] | req_valid[i];
      cand_data[i]  = slot_v[i] ? slot_data[i] : req_data[i*DW +: DW];
      cand_idx[i]   = slot_v[i] ? slot_idx[i]  : req_rob_idx[i*IDXW +: IDXW];
      cand_prd[i]   = slot_v[i] ? slot_prd[i]  : req_P_rd[i*PRW +: PRW];
      cand_flush[i] = cand_v[i] & mispredict & flush_mask[cand_idx[i]];
      cand_live[i]  = cand_v[i] & ~cand_flush[i];
      cand_age[i]   = cand_idx[i] - ROB_h;
    end
  end

  // Strict less-than keeps the lowest requester on an age tie.
  always_comb begin
    win_any    = 1'b0;
    win_onehot = '0;
    best_age   = '1;
    for (int i = 0; i < N_REQ; i++) begin
      if (cand_live[i] && (!win_any || cand_age[i] < best_age)) begin
        win_any    = 1'b1;
        win_onehot = '0;
        win_onehot[i] = 1'b1;
        best_age   = cand_age[i];
      end
    end
  end

  always_comb begin
    win_data = '0;
    win_idx  = '0;
    win_prd  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_onehot[i]) begin
        win_data = cand_data[i];
        win_idx  = cand_idx[i];
        win_prd  = cand_prd[i];
      end
    end
  end

  // Drops include flushed candidates plus a squashed result already sitting on the output.
  always_comb begin
    out_kill = wb_v_r & mispredict & flush_mask[wb_idx_r];
    drop_inc = CW'(out_kill);
    for (int i = 0; i < N_REQ; i++) begin
      drop_inc = drop_inc + CW'(cand_flush[i]);
    end
    drop_sum  = 17'(drop_cnt_r) + 17'(drop_inc);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v     <= '0;
      wb_v_r     <= 1'b0;
      wb_data_r  <= '0;
      wb_idx_r   <= '0;
      wb_prd_r   <= '0;
      drop_cnt_r <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        slot_data[i] <= '0;
        slot_idx[i]  <= '0;
        slot_prd[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (slot_v[i]) begin
          if (cand_flush[i] || win_onehot[i]) slot_v[i] <= 1'b0;
        end else if (req_valid[i] && !cand_flush[i] && !win_onehot[i]) begin
          slot_v[i]    <= 1'b1;
          slot_data[i] <= req_data[i*DW +: DW];
          slot_idx[i]  <= req_rob_idx[i*IDXW +: IDXW];
          slot_prd[i]  <= req_P_rd[i*PRW +: PRW];
        end
      end
      wb_v_r <= win_any;
      if (win_any) begin
        wb_data_r <= win_data;
        wb_idx_r  <= win_idx;
        wb_prd_r  <= win_prd;
      end
      drop_cnt_r <= drop_next;
    end
  end

  assign req_ready  = rst ? '0 : ~slot_v;
  assign WB_valid   = wb_v_r & ~(mispredict & flush_mask[wb_idx_r]);
  assign WB_data    = wb_data_r;
  assign WB_rob_idx = wb_idx_r;
  assign WB_P_rd    = wb_prd_r;
  assign drop_cnt   = drop_cnt_r;

endmodule
